// File: rtl/lut_sched_pkg.sv
// Shared types and helpers for the time-multiplexed LUT-neuron layer scheduler.
// Optional feature macro used by the top: LUT_SCHED_PERF_EN.
package lut_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Upper bound on packed map width accepted by map_slice()
  localparam int MAP_MAX = 1024;

  // Width of one connectivity index for an input vector of in_w bits
  function automatic int idx_w(input int in_w);
    return $clog2(in_w);
  endfunction

  // Width of a truth-table address for a neuron of fan-in in_bits
  function automatic int addr_w(input int in_bits);
    return in_bits;
  endfunction

  // Extract connection j (idx_w bits wide) from a packed connectivity map
  function automatic int unsigned map_slice(input logic [MAP_MAX-1:0] map,
                                            input int idx_w_in,
                                            input int j);
    logic [MAP_MAX-1:0] s;
    s = map >> (j * idx_w_in);
    return s[31:0] & ((32'd1 << idx_w_in) - 32'd1);
  endfunction

endpackage

// File: rtl/lut_neuron_gather.sv
// Combinational gather: builds one neuron's truth-table address from the
// latched layer input and that neuron's packed connectivity map.
// Indices that point past the real input width read as constant 0.
module lut_neuron_gather
  import lut_sched_pkg::*;
#(
  parameter int IN_BITS = 6,
  parameter int IN_W    = 64
) (
  input  logic [IN_W-1:0]                   i_in,
  input  logic [IN_BITS*idx_w(IN_W)-1:0]    i_map,
  output logic [addr_w(IN_BITS)-1:0]        o_addr
);

  localparam int IDX_W = idx_w(IN_W);
  localparam int PAD_W = 2 ** IDX_W;

  // Zero-extended input so every representable index selects a defined bit
  logic [PAD_W-1:0] w_pad;
  assign w_pad = PAD_W'(i_in);

  // Address bit j comes from the input bit named by map slice j
  always_comb begin
    o_addr = '0;
    for (int j = 0; j < IN_BITS; j++) begin
      o_addr[j] = w_pad[IDX_W'(map_slice(MAP_MAX'(i_map), IDX_W, j))];
    end
  end

endmodule

// File: rtl/lut_layer_scheduler.sv
// Time-multiplexed evaluator for one sparse LUT-neuron layer: one neuron is
// gathered and looked up per cycle through a single shared datapath.
// Optional: define LUT_SCHED_PERF_EN to add perf_inf / perf_stall counters.
module lut_layer_scheduler
  import lut_sched_pkg::*;
#(
  parameter int IN_BITS     = 6,
  parameter int NUM_NEURONS = 16,
  parameter int IN_W        = 64
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            s_valid,
  output logic                                            s_ready,
  input  logic [IN_W-1:0]                                 s_data,
  output logic                                            m_valid,
  input  logic                                            m_ready,
  output logic [NUM_NEURONS-1:0]                          m_data,
  output logic                                            cfg_ready,
  input  logic                                            cfg_tbl_we,
  input  logic                                            cfg_map_we,
  input  logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] cfg_neuron,
  input  logic [2**IN_BITS-1:0]                           cfg_tbl,
  input  logic [IN_BITS*idx_w(IN_W)-1:0]                  cfg_map
`ifdef LUT_SCHED_PERF_EN
  ,
  output logic [31:0]                                     perf_inf,
  output logic [31:0]                                     perf_stall
`endif
);

  localparam int IDX_W = idx_w(IN_W);
  localparam int DEPTH = 2 ** IN_BITS;
  localparam int MAP_W = IN_BITS * IDX_W;
  localparam int NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  // Control state
  state_e                  r_state;
  logic [NW-1:0]           r_cnt;
  logic [IN_W-1:0]         r_in_lat;
  logic                    r_m_valid;
  logic [NUM_NEURONS-1:0]  r_m_data;

  // Runtime-loadable neuron storage; deliberately not reset
  logic [DEPTH-1:0]        r_tbl [NUM_NEURONS];
  logic [MAP_W-1:0]        r_map [NUM_NEURONS];

  logic                    w_idle;
  logic                    w_last;
  logic [MAP_W-1:0]        w_map;
  logic [DEPTH-1:0]        w_tbl_row;
  logic [IN_BITS-1:0]      w_addr;
  logic                    w_res;

  assign w_idle    = (r_state == IDLE);
  assign s_ready   = w_idle;
  assign cfg_ready = w_idle;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;

  assign w_last    = (r_cnt == NW'(NUM_NEURONS - 1));
  assign w_map     = r_map[r_cnt];
  assign w_tbl_row = r_tbl[r_cnt];
  assign w_res     = w_tbl_row[w_addr];

  lut_neuron_gather #(
    .IN_BITS (IN_BITS),
    .IN_W    (IN_W)
  ) u_gather (
    .i_in   (r_in_lat),
    .i_map  (w_map),
    .o_addr (w_addr)
  );

  // Scheduler FSM: accept a vector, walk all neurons, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_in_lat  <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_valid) begin
            r_in_lat <= s_data;
            r_cnt    <= '0;
            r_state  <= EVAL;
          end
        end
        EVAL: begin
          r_m_data[r_cnt] <= w_res;
          if (w_last) begin
            r_cnt     <= '0;
            r_m_valid <= 1'b1;
            r_state   <= OUT;
          end else begin
            r_cnt <= r_cnt + NW'(1);
          end
        end
        OUT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Configuration writes land only while idle; otherwise they are dropped
  always_ff @(posedge clk) begin
    if (w_idle) begin
      if (cfg_tbl_we) r_tbl[cfg_neuron] <= cfg_tbl;
      if (cfg_map_we) r_map[cfg_neuron] <= cfg_map;
    end
  end

`ifdef LUT_SCHED_PERF_EN
  logic [31:0] r_perf_inf;
  logic [31:0] r_perf_stall;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign perf_inf   = r_perf_inf;
  assign perf_stall = r_perf_stall;

  // Count completed output handshakes and cycles stalled by downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_inf   <= '0;
      r_perf_stall <= '0;
    end else if (r_state == OUT) begin
      if (m_ready) r_perf_inf   <= sat_inc(r_perf_inf);
      else         r_perf_stall <= sat_inc(r_perf_stall);
    end
  end
`endif

endmodule
